// File: rtl/seq_det_pkg.sv
// Shared constants and the prefix-matching transition function for the serial pattern detector.
package seq_det_pkg;

  localparam int SEQ_DET_MAX_WIDTH = 16;

  // Returns the number of pattern-prefix bits still matched after appending din_b
  // to a matched prefix of length state. A full match falls back to the longest
  // proper border, which is what lets matches overlap. Pattern MSB is the first bit.
  function automatic int seq_det_next(input logic [SEQ_DET_MAX_WIDTH-1:0] pattern,
                                      input int width, input int state,
                                      input logic din_b);
    logic [SEQ_DET_MAX_WIDTH:0] s;
    int   len;
    int   best;
    logic ok;
    s = '0;
    for (int j = 0; j < state; j++) s[j] = pattern[width-1-j];
    s[state] = din_b;
    len  = state + 1;
    best = 0;
    for (int k = 1; k <= len && k < width; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (s[len-k+i] != pattern[width-1-i]) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

endpackage

// File: rtl/mealy_overlapping_seq_detector.sv
// Mealy serial pattern detector with overlapping matches; dout is combinational.
// Optional saturating match counter when SEQ_DET_COUNT_EN is defined.
module mealy_overlapping_seq_detector
  import seq_det_pkg::*;
#(
  parameter int                   SEQ_WIDTH   = 4,
  parameter logic [SEQ_WIDTH-1:0] SEQ_PATTERN = 4'b1011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
`ifdef SEQ_DET_COUNT_EN
  output logic [15:0] match_count,
`endif
  output logic        dout
);

  localparam int                           SW      = (SEQ_WIDTH > 1) ? $clog2(SEQ_WIDTH) : 1;
  localparam int                           NSTATES = 1 << SW;
  localparam logic [SEQ_DET_MAX_WIDTH-1:0] PAT_EXT = SEQ_DET_MAX_WIDTH'(SEQ_PATTERN);
  localparam logic [SW-1:0]                LAST    = SW'(SEQ_WIDTH - 1);

  logic [SW-1:0] state_q, state_d;

  // Transition table resolved at elaboration; unreachable encodings fall back to S0.
  logic [NSTATES-1:0][1:0][SW-1:0] nxt_tbl;

  for (genvar gs = 0; gs < NSTATES; gs++) begin : g_state
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      if (gs < SEQ_WIDTH) begin : g_live
        localparam int NX = seq_det_next(PAT_EXT, SEQ_WIDTH, gs, gb[0]);
        assign nxt_tbl[gs][gb] = SW'(NX);
      end else begin : g_dead
        assign nxt_tbl[gs][gb] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= '0;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = nxt_tbl[state_q][din];
  end

  always_comb begin
    dout = rst && (state_q == LAST) && (din == SEQ_PATTERN[0]);
  end

`ifdef SEQ_DET_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (dout && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_mealy_overlapping_seq_detector.sv
// Randomized + directed bench for mealy_overlapping_seq_detector against a sliding-window model.
module tb_mealy_overlapping_seq_detector;

  localparam int NDUT = 3;
  localparam int W [NDUT] = '{4, 4, 5};
  localparam logic [31:0] P [NDUT] = '{32'hB, 32'h9, 32'h1B};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic [NDUT-1:0] dout;
  logic [NDUT-1:0][15:0] cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] hist  [NDUT];
  int          nbits [NDUT];
  int          mcnt  [NDUT];

  always #5 clk = ~clk;

  mealy_overlapping_seq_detector #(.SEQ_WIDTH(4), .SEQ_PATTERN(4'b1011)) dut0 (
    .clk(clk), .rst(rst), .din(din),
`ifdef SEQ_DET_COUNT_EN
    .match_count(cnt[0]),
`endif
    .dout(dout[0]));
  mealy_overlapping_seq_detector #(.SEQ_WIDTH(4), .SEQ_PATTERN(4'b1001)) dut1 (
    .clk(clk), .rst(rst), .din(din),
`ifdef SEQ_DET_COUNT_EN
    .match_count(cnt[1]),
`endif
    .dout(dout[1]));
  mealy_overlapping_seq_detector #(.SEQ_WIDTH(5), .SEQ_PATTERN(5'b11011)) dut2 (
    .clk(clk), .rst(rst), .din(din),
`ifdef SEQ_DET_COUNT_EN
    .match_count(cnt[2]),
`endif
    .dout(dout[2]));

`ifndef SEQ_DET_COUNT_EN
  assign cnt = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected flag: the last W bits since reset (current din included) equal the pattern.
  function automatic logic model_hit(input int k, input logic b);
    logic [31:0] s;
    logic [31:0] mask;
    s    = {hist[k][30:0], b};
    mask = (32'd1 << W[k]) - 32'd1;
    return (nbits[k] >= W[k] - 1) && ((s & mask) == P[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      hist[k] = '0; nbits[k] = 0; mcnt[k] = 0;
    end
  endtask

  // Called shortly after a negedge; drives one bit, checks, and advances past the next posedge.
  task automatic step(input logic b, input string tag);
    logic e;
    din = b;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      e = model_hit(k, b);
      chk($sformatf("%s dout%0d", tag, k), {31'd0, dout[k]}, {31'd0, e});
`ifdef SEQ_DET_COUNT_EN
      chk($sformatf("%s cnt%0d", tag, k), {16'd0, cnt[k]}, mcnt[k]);
      if (e && mcnt[k] < 65535) mcnt[k]++;
`endif
      hist[k] = {hist[k][30:0], b};
      nbits[k]++;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic run_bits(input string bits, input string tag);
    for (int i = 0; i < bits.len(); i++) step(bits[i] == "1", $sformatf("%s[%0d]", tag, i + 1));
  endtask

  task automatic do_reset(input int n, input string tag);
    rst = 1'b0;
    din = 1'b1;
    #1;
    chk({tag, " state"}, {30'd0, dut0.state_q}, 32'd0);
    chk({tag, " dout"}, {29'd0, dout}, 32'd0);
    repeat (n) begin
      @(negedge clk);
      #1;
      chk({tag, " hold state"}, {30'd0, dut0.state_q}, 32'd0);
      chk({tag, " hold dout"}, {29'd0, dout}, 32'd0);
`ifdef SEQ_DET_COUNT_EN
      chk({tag, " cnt"}, {16'd0, cnt[0]}, 32'd0);
`endif
    end
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    do_reset(2, "reset");
    chk("post-reset state", {30'd0, dut0.state_q}, 32'd0);

    run_bits("10010110111", "t2");
`ifdef SEQ_DET_COUNT_EN
    chk("t2 final cnt", {16'd0, cnt[0]}, 32'd2);
`endif

    do_reset(1, "r3");
    run_bits("101", "t3");
    #1;
    rst = 1'b0;
    #1;
    chk("t3 async state", {30'd0, dut0.state_q}, 32'd0);
    din = 1'b1;
    #1;
    chk("t3 dout in reset", {29'd0, dout}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    step(1'b1, "t3 after");
    chk("t3 state S1", {30'd0, dut0.state_q}, 32'd1);

    do_reset(1, "r4");
    run_bits("1011011011", "t4");

    do_reset(1, "r5");
    for (int i = 0; i < 20; i++) step(1'b0, "t5 zeros");
    for (int i = 0; i < 20; i++) step(1'b1, "t5 ones");

    do_reset(1, "r6");
    run_bits("1001001", "t6");

    do_reset(1, "rr");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset(1, "rnd rst");
      step(1'($urandom_range(0, 1)), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
